// File: rtl/nv_nvdla_hls_mul_prescale_pkg.sv
// rtl/nv_nvdla_hls_mul_prescale_pkg.sv - shared widths, bypass encoding and width check
package nv_nvdla_hls_mul_prescale_pkg;

    localparam int DEF_IN_WIDTH    = 32;
    localparam int DEF_OP_WIDTH    = 16;
    localparam int DEF_OUT_WIDTH   = 49;
    localparam int DEF_SHIFT_WIDTH = 6;

    typedef enum logic {
        MODE_SCALE  = 1'b0,
        MODE_BYPASS = 1'b1
    } mode_e;

    // The product must fit in the output without truncation.
    function automatic bit width_ok(input int out_w, input int in_w, input int op_w);
        return out_w >= in_w + op_w;
    endfunction

endpackage

// File: rtl/nv_nvdla_hls_pipe_reg.sv
// rtl/nv_nvdla_hls_pipe_reg.sv - valid/ready register slice with bubble collapse
module nv_nvdla_hls_pipe_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up_vld,
    output logic             up_rdy,
    input  logic [WIDTH-1:0] up_data,
    output logic             dn_vld,
    input  logic             dn_rdy,
    output logic [WIDTH-1:0] dn_data
);

    logic             vld;
    logic [WIDTH-1:0] data;

    assign up_rdy  = !vld || dn_rdy;
    assign dn_vld  = vld;
    assign dn_data = data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld  <= 1'b0;
            data <= '0;
        end else begin
            if (up_rdy) begin
                vld <= up_vld;
            end
            if (up_vld && up_rdy) begin
                data <= up_data;
            end
        end
    end

endmodule

// File: rtl/nv_nvdla_hls_mul_prescale.sv
// rtl/nv_nvdla_hls_mul_prescale.sv - two-stage signed multiply ahead of shift-round-saturate
module nv_nvdla_hls_mul_prescale
    import nv_nvdla_hls_mul_prescale_pkg::*;
#(
    parameter int IN_WIDTH    = DEF_IN_WIDTH,
    parameter int OP_WIDTH    = DEF_OP_WIDTH,
    parameter int OUT_WIDTH   = DEF_OUT_WIDTH,
    parameter int SHIFT_WIDTH = DEF_SHIFT_WIDTH
) (
    input  logic                   nvdla_core_clk,
    input  logic                   nvdla_core_rst,
    input  logic                   in_pvld,
    output logic                   in_prdy,
    input  logic [IN_WIDTH-1:0]    in_data,
    input  logic [OP_WIDTH-1:0]    in_op,
    input  logic                   cfg_bypass,
    input  logic [SHIFT_WIDTH-1:0] cfg_shift,
    output logic                   out_pvld,
    input  logic                   out_prdy,
    output logic [OUT_WIDTH-1:0]   out_data,
    output logic [SHIFT_WIDTH-1:0] out_shift,
    output logic                   idle
);

    localparam int S1_WIDTH = IN_WIDTH + OP_WIDTH + 1 + SHIFT_WIDTH;
    localparam int S2_WIDTH = OUT_WIDTH + SHIFT_WIDTH;

    if (!width_ok(OUT_WIDTH, IN_WIDTH, OP_WIDTH)) begin : g_width_check
        $error("OUT_WIDTH too narrow for IN_WIDTH+OP_WIDTH product");
    end

    logic                   s1_vld;
    logic                   s1_rdy;
    logic [S1_WIDTH-1:0]    s1_payload;
    logic                   s2_vld;
    logic                   s2_rdy;
    logic [S2_WIDTH-1:0]    s2_payload;
    logic [S2_WIDTH-1:0]    s2_next;

    logic signed [IN_WIDTH-1:0]  s1_data;
    logic signed [OP_WIDTH-1:0]  s1_op;
    logic                        s1_bypass;
    logic [SHIFT_WIDTH-1:0]      s1_shift;
    logic signed [OUT_WIDTH-1:0] s1_result;
    logic [SHIFT_WIDTH-1:0]      s1_result_shift;

    nv_nvdla_hls_pipe_reg #(.WIDTH(S1_WIDTH)) u_s1 (
        .clk     (nvdla_core_clk),
        .rst     (nvdla_core_rst),
        .up_vld  (in_pvld),
        .up_rdy  (s1_rdy),
        .up_data ({in_data, in_op, cfg_bypass, cfg_shift}),
        .dn_vld  (s1_vld),
        .dn_rdy  (s2_rdy),
        .dn_data (s1_payload)
    );

    assign {s1_data, s1_op, s1_bypass, s1_shift} = s1_payload;

    // Operands are sign-extended to the output width first, so the product is exact.
    always_comb begin
        s1_result       = OUT_WIDTH'(s1_data) * OUT_WIDTH'(s1_op);
        s1_result_shift = s1_shift;
        if (mode_e'(s1_bypass) == MODE_BYPASS) begin
            s1_result       = OUT_WIDTH'(s1_data);
            s1_result_shift = '0;
        end
    end

    assign s2_next = {s1_result, s1_result_shift};

    nv_nvdla_hls_pipe_reg #(.WIDTH(S2_WIDTH)) u_s2 (
        .clk     (nvdla_core_clk),
        .rst     (nvdla_core_rst),
        .up_vld  (s1_vld),
        .up_rdy  (s2_rdy),
        .up_data (s2_next),
        .dn_vld  (s2_vld),
        .dn_rdy  (out_prdy),
        .dn_data (s2_payload)
    );

    assign in_prdy                = s1_rdy;
    assign out_pvld               = s2_vld;
    assign {out_data, out_shift}  = s2_payload;
    assign idle                   = !s1_vld && !s2_vld;

endmodule

// File: tb/tb_nv_nvdla_hls_mul_prescale.sv
// tb/tb_nv_nvdla_hls_mul_prescale.sv - directed bench for the multiply prescale stage
module tb_nv_nvdla_hls_mul_prescale;

    logic        clk;
    logic        rst;
    logic        in_pvld;
    logic        in_prdy;
    logic [31:0] in_data;
    logic [15:0] in_op;
    logic        cfg_bypass;
    logic [5:0]  cfg_shift;
    logic        out_pvld;
    logic        out_prdy;
    logic [48:0] out_data;
    logic [5:0]  out_shift;
    logic        idle;

    int total = 0;
    int bad   = 0;

    nv_nvdla_hls_mul_prescale dut (
        .nvdla_core_clk (clk),
        .nvdla_core_rst (rst),
        .in_pvld        (in_pvld),
        .in_prdy        (in_prdy),
        .in_data        (in_data),
        .in_op          (in_op),
        .cfg_bypass     (cfg_bypass),
        .cfg_shift      (cfg_shift),
        .out_pvld       (out_pvld),
        .out_prdy       (out_prdy),
        .out_data       (out_data),
        .out_shift      (out_shift),
        .idle           (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [48:0] bp_expect(input int i);
        longint p;
        p = longint'(100 + 7 * i) * longint'(i - 3);
        return p[48:0];
    endfunction

    logic [48:0] exp_d;
    logic [48:0] prev_data;
    logic [5:0]  prev_shift;
    logic        stalled_prev;
    logic        in_x;
    logic        out_x;
    int          sent;
    int          recv;

    initial begin
        rst = 1'b0; in_pvld = 1'b0; in_data = '0; in_op = '0;
        cfg_bypass = 1'b0; cfg_shift = '0; out_prdy = 1'b0;
        #1 rst = 1'b1;
        #2;
        chk("rst_out_pvld", 64'(out_pvld), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_shift", 64'(out_shift), 64'd0);
        chk("rst_idle", 64'(idle), 64'd1);
        step();
        rst = 1'b0;
        step();
        chk("rel_in_prdy", 64'(in_prdy), 64'd1);
        chk("rel_idle", 64'(idle), 64'd1);

        // basic multiply
        out_prdy = 1'b1;
        in_pvld = 1'b1; in_data = 32'd1000; in_op = -16'sd3; cfg_shift = 6'd4; cfg_bypass = 1'b0;
        step();
        in_pvld = 1'b0;
        chk("basic_lat_pvld", 64'(out_pvld), 64'd0);
        chk("basic_lat_idle", 64'(idle), 64'd0);
        step();
        exp_d = -49'sd3000;
        chk("basic_pvld", 64'(out_pvld), 64'd1);
        chk("basic_data", 64'(out_data), 64'(exp_d));
        chk("basic_shift", 64'(out_shift), 64'd4);
        step();
        chk("basic_drain_idle", 64'(idle), 64'd1);

        // extremes back to back
        in_pvld = 1'b1; in_data = 32'h8000_0000; in_op = 16'h8000; cfg_shift = 6'd1;
        step();
        in_data = 32'h7fff_ffff; in_op = 16'h8000; cfg_shift = 6'd2;
        step();
        in_pvld = 1'b0;
        exp_d = 49'd70368744177664;
        chk("ext_max_data", 64'(out_data), 64'(exp_d));
        chk("ext_max_bit48", 64'(out_data[48]), 64'd0);
        chk("ext_max_shift", 64'(out_shift), 64'd1);
        step();
        exp_d = -49'sd70368744144896;
        chk("ext_min_data", 64'(out_data), 64'(exp_d));
        chk("ext_min_pvld", 64'(out_pvld), 64'd1);
        step();

        // bypass
        in_pvld = 1'b1; in_data = -32'sd5; in_op = 16'sd7; cfg_shift = 6'd9; cfg_bypass = 1'b1;
        step();
        in_pvld = 1'b0; cfg_bypass = 1'b0;
        step();
        exp_d = -49'sd5;
        chk("byp_data", 64'(out_data), 64'(exp_d));
        chk("byp_shift", 64'(out_shift), 64'd0);
        step();

        // backpressure with out_prdy 1,0,0 repeating
        sent = 0; recv = 0; stalled_prev = 1'b0; prev_data = '0; prev_shift = '0;
        for (int c = 0; c < 80 && recv < 10; c++) begin
            out_prdy = (c % 3 == 0);
            in_pvld = (sent < 10);
            in_data = 32'(100 + 7 * sent);
            in_op = 16'(sent - 3);
            cfg_shift = 6'(sent);
            #1;
            chk("bp_in_prdy", 64'(in_prdy), 64'(!((sent - recv) == 2 && !out_prdy)));
            if (stalled_prev) begin
                chk("bp_hold_pvld", 64'(out_pvld), 64'd1);
                chk("bp_hold_data", 64'(out_data), 64'(prev_data));
                chk("bp_hold_shift", 64'(out_shift), 64'(prev_shift));
            end
            in_x = in_pvld && in_prdy;
            out_x = out_pvld && out_prdy;
            if (out_x) begin
                chk("bp_data", 64'(out_data), 64'(bp_expect(recv)));
                chk("bp_shift", 64'(out_shift), 64'(recv));
            end
            stalled_prev = out_pvld && !out_prdy;
            prev_data = out_data;
            prev_shift = out_shift;
            step();
            if (in_x) sent++;
            if (out_x) recv++;
        end
        chk("bp_count", 64'(recv), 64'd10);
        in_pvld = 1'b0; out_prdy = 1'b1;
        step();
        step();
        chk("bp_idle", 64'(idle), 64'd1);

        // config change between elements 2 and 3
        sent = 0; recv = 0;
        for (int c = 0; c < 20 && recv < 5; c++) begin
            in_pvld = (sent < 5);
            in_data = 32'(sent + 1);
            in_op = 16'd2;
            cfg_shift = (sent < 3) ? 6'd3 : 6'd7;
            #1;
            in_x = in_pvld && in_prdy;
            out_x = out_pvld && out_prdy;
            if (out_x) begin
                chk("cfg_shift", 64'(out_shift), (recv < 3) ? 64'd3 : 64'd7);
                chk("cfg_data", 64'(out_data), 64'(2 * (recv + 1)));
            end
            step();
            if (in_x) sent++;
            if (out_x) recv++;
        end
        chk("cfg_count", 64'(recv), 64'd5);
        in_pvld = 1'b0;
        step();

        // async reset with both stages full
        out_prdy = 1'b0;
        in_pvld = 1'b1; in_data = 32'd11; in_op = 16'd1; cfg_shift = 6'd5;
        step();
        in_data = 32'd12;
        step();
        in_pvld = 1'b0;
        chk("full_in_prdy", 64'(in_prdy), 64'd0);
        chk("full_pvld", 64'(out_pvld), 64'd1);
        chk("full_idle", 64'(idle), 64'd0);
        #2 rst = 1'b1;
        #1;
        chk("arst_pvld", 64'(out_pvld), 64'd0);
        chk("arst_idle", 64'(idle), 64'd1);
        chk("arst_data", 64'(out_data), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        out_prdy = 1'b1;
        step();
        chk("post_idle", 64'(idle), 64'd1);
        chk("post_in_prdy", 64'(in_prdy), 64'd1);
        chk("post_pvld", 64'(out_pvld), 64'd0);
        step();
        chk("post_pvld2", 64'(out_pvld), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
